// File: rtl/lsu_rmw_ctrl.sv
// Load/store unit: turns byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into
// word-wide memory accesses, with sub-word stores done as a read-modify-write.
module lsu_rmw_ctrl #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ready,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_wren,
    input  logic [31:0] i_mem_rdata
);

    localparam int unsigned WIDX_W = 30;
    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;
    localparam logic [1:0]  SZ_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_e;

    state_e      state_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] merge_q;
    logic [31:0] rdata_q;

    logic        req_err;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    // Request legality: alignment, size encoding and word-index range.
    always_comb begin
        req_err = 1'b0;
        case (i_size)
            SZ_BYTE: req_err = 1'b0;
            SZ_HALF: req_err = i_addr[0];
            SZ_WORD: req_err = |i_addr[1:0];
            default: req_err = 1'b1;
        endcase
        if (i_addr[31:2] >= WIDX_W'(MEM_WORDS)) begin
            req_err = 1'b1;
        end
    end

    // Lane extraction and extension for loads.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_sel = i_mem_rdata[7:0];
            2'd1:    byte_sel = i_mem_rdata[15:8];
            2'd2:    byte_sel = i_mem_rdata[23:16];
            default: byte_sel = i_mem_rdata[31:24];
        endcase
        half_sel = addr_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (size_q)
            SZ_BYTE: load_data = unsigned_q ? {24'h0, byte_sel}
                                            : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = unsigned_q ? {16'h0, half_sel}
                                            : {{16{half_sel[15]}}, half_sel};
            default: load_data = i_mem_rdata;
        endcase
    end

    // Sub-word store merge: only the addressed lane is replaced.
    always_comb begin
        merge_data = i_mem_rdata;
        if (size_q == SZ_BYTE) begin
            case (addr_q[1:0])
                2'd0:    merge_data[7:0]   = wdata_q[7:0];
                2'd1:    merge_data[15:8]  = wdata_q[7:0];
                2'd2:    merge_data[23:16] = wdata_q[7:0];
                default: merge_data[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merge_data[31:16] = wdata_q[15:0];
        end else begin
            merge_data[15:0] = wdata_q[15:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            err_q      <= 1'b0;
            merge_q    <= 32'h0;
            rdata_q    <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req) begin
                        we_q       <= i_we;
                        size_q     <= i_size;
                        unsigned_q <= i_unsigned;
                        addr_q     <= i_addr;
                        wdata_q    <= i_wdata;
                        err_q      <= req_err;
                        state_q    <= req_err ? RESP : ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        rdata_q <= load_data;
                        state_q <= RESP;
                    end else if (size_q == SZ_WORD) begin
                        state_q <= RESP;
                    end else begin
                        merge_q <= merge_data;
                        state_q <= WRITE;
                    end
                end
                WRITE:   state_q <= RESP;
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Word stores write straight from ACCESS; sub-word stores write the merged word in WRITE.
    assign o_mem_wren  = (state_q == WRITE) ||
                         ((state_q == ACCESS) && we_q && (size_q == SZ_WORD));
    assign o_mem_wdata = (state_q == WRITE) ? merge_q : wdata_q;
    assign o_mem_addr  = {2'b00, addr_q[31:2]};
    assign o_ready     = (state_q == IDLE);
    assign o_done      = (state_q == RESP);
    assign o_err       = (state_q == RESP) && err_q;
    assign o_rdata     = rdata_q;

endmodule

// File: tb/tb_lsu_rmw_ctrl.sv
// Directed bench for lsu_rmw_ctrl: vector table of single requests against a
// behavioural word memory, plus back-to-back and reset-abort sequences.
module tb_lsu_rmw_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        ready, done, err;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_wren;

    logic [31:0] mem [0:255];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_idx = 8'h0;
    logic [31:0] pre_val = 32'h0;
    int          wr_cnt = 0;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    lsu_rmw_ctrl #(.MEM_WORDS(256)) dut (
        .i_clk(clk), .i_reset(rst), .i_req(req), .i_we(we), .i_size(size),
        .i_unsigned(uns), .i_addr(addr), .i_wdata(wdata),
        .o_ready(ready), .o_done(done), .o_err(err), .o_rdata(rdata),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wren(mem_wren),
        .i_mem_rdata(mem_rdata)
    );

    assign mem_rdata = (mem_addr < 32'd256) ? mem[mem_addr[7:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_wren) begin
            wr_cnt <= wr_cnt + 1;
            if (mem_addr < 32'd256) mem[mem_addr[7:0]] <= mem_wdata;
        end else if (pre_en) begin
            mem[pre_idx] <= pre_val;
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          lat;
        logic [31:0] exp_mem;
        int          exp_wr;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        @(negedge clk);
        pre_idx = idx;
        pre_val = val;
        pre_en  = 1'b1;
        @(negedge clk);
        pre_en  = 1'b0;
    endtask

    // Issue one request at the next negedge; return cycles from accept to o_done.
    task automatic issue(input string nm, input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d, output int lat);
        @(negedge clk);
        chk({nm, " ready"}, 32'(ready), 32'd1);
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
        if (!done) lat = 99;
    endtask

    task automatic run_vec(input int i, input vec_t t);
        int lat, w0;
        logic [31:0] exp_rd;
        string nm;
        nm = $sformatf("vec%0d", i);
        if (t.addr[31:2] < 30'd256) preload(t.addr[9:2], t.init);
        w0 = wr_cnt;
        issue(nm, t.we, t.size, t.uns, t.addr, t.wdata, lat);
        exp_rd = (!t.we && !t.exp_err) ? t.exp_rd : last_rd;
        last_rd = exp_rd;
        chk({nm, " latency"}, 32'(lat), 32'(t.lat));
        chk({nm, " err"}, 32'(err), 32'(t.exp_err));
        chk({nm, " rdata"}, rdata, exp_rd);
        chk({nm, " writes"}, 32'(wr_cnt - w0), 32'(t.exp_wr));
        if (t.addr[31:2] < 30'd256) chk({nm, " mem"}, mem[t.addr[9:2]], t.exp_mem);
    endtask

    initial begin
        int lat, w0;
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
        addr = 32'h0; wdata = 32'h0; last_rd = 32'h0;
        for (int k = 0; k < 256; k++) mem[k] = 32'h0;

        //         we    sz     u     addr          wdata         init          exp_rd       err  lat exp_mem     wr
        vq.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2, 32'hDEADBEEF, 0});
        vq.push_back('{1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,        32'h80FF1234, 32'hFFFFFF80, 1'b0, 2, 32'h80FF1234, 0});
        vq.push_back('{1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,        32'h80FF1234, 32'h00000080, 1'b0, 2, 32'h80FF1234, 0});
        vq.push_back('{1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,        32'h80FF1234, 32'hFFFF80FF, 1'b0, 2, 32'h80FF1234, 0});
        vq.push_back('{1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0,        32'h80FF1234, 32'h00001234, 1'b0, 2, 32'h80FF1234, 0});
        vq.push_back('{1'b0, 2'b00, 1'b0, 32'h0000_0012, 32'h0,        32'h80FF1234, 32'hFFFFFFFF, 1'b0, 2, 32'h80FF1234, 0});
        vq.push_back('{1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0,        32'h80FF1234, 32'h00000034, 1'b0, 2, 32'h80FF1234, 0});
        vq.push_back('{1'b0, 2'b10, 1'b1, 32'h0000_03FC, 32'h0,        32'hFBADF00D, 32'hFBADF00D, 1'b0, 2, 32'hFBADF00D, 0});
        vq.push_back('{1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'h0,        32'h01020304, 32'h0,        1'b1, 1, 32'h01020304, 0});
        vq.push_back('{1'b1, 2'b10, 1'b0, 32'h0000_0002, 32'hFFFFFFFF, 32'h01020304, 32'h0,        1'b1, 1, 32'h01020304, 0});
        vq.push_back('{1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,        32'h00000077, 32'h0,        1'b1, 1, 32'h00000077, 0});
        vq.push_back('{1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'hFFFFFFFF, 32'h00000077, 32'h0,        1'b1, 1, 32'h00000077, 0});
        vq.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0,        32'h0,        32'h0,        1'b1, 1, 32'h0,        0});
        vq.push_back('{1'b1, 2'b01, 1'b0, 32'h0000_0005, 32'hFFFF,     32'h12345678, 32'h0,        1'b1, 1, 32'h12345678, 0});
        vq.push_back('{1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h000000AA, 32'h11223344, 32'h0,        1'b0, 3, 32'h1122AA44, 1});
        vq.push_back('{1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h0000BEEF, 32'h11223344, 32'h0,        1'b0, 3, 32'hBEEF3344, 1});
        vq.push_back('{1'b1, 2'b10, 1'b0, 32'h0000_0014, 32'hCAFEF00D, 32'h0,        32'h0,        1'b0, 2, 32'hCAFEF00D, 1});
        vq.push_back('{1'b1, 2'b00, 1'b0, 32'h0000_03FF, 32'h12345655, 32'hA0B0C0D0, 32'h0,        1'b0, 3, 32'h55B0C0D0, 1});
        vq.push_back('{1'b1, 2'b01, 1'b0, 32'h0000_0010, 32'hFFFF1234, 32'hA0B0C0D0, 32'h0,        1'b0, 3, 32'hA0B01234, 1});
        vq.push_back('{1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h00000001, 32'h11223344, 32'h0,        1'b0, 3, 32'h01223344, 1});

        repeat (2) @(negedge clk);
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset done", 32'(done), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset rdata", rdata, 32'h0);
        chk("reset wren", 32'(mem_wren), 32'd0);
        rst = 1'b0;

        foreach (vq[i]) run_vec(i, vq[i]);

        // SH followed immediately by SW the cycle after o_done.
        preload(8'd4, 32'h11223344);
        preload(8'd5, 32'h0);
        w0 = wr_cnt;
        issue("b2b sh", 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000BEEF, lat);
        chk("b2b sh latency", 32'(lat), 32'd3);
        issue("b2b sw", 1'b1, 2'b10, 1'b0, 32'h14, 32'h5A5A_A5A5, lat);
        chk("b2b sw latency", 32'(lat), 32'd2);
        chk("b2b mem4", mem[4], 32'hBEEF3344);
        chk("b2b mem5", mem[5], 32'h5A5AA5A5);
        chk("b2b writes", 32'(wr_cnt - w0), 32'd2);
        @(negedge clk);
        chk("b2b done pulse", 32'(done), 32'd0);

        // Reset while a sub-word store sits in WRITE.
        preload(8'd8, 32'h11223344);
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h21; wdata = 32'hAA;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort in write", 32'(mem_wren), 32'd1);
        w0 = wr_cnt;
        rst = 1'b1;
        #1 chk("abort wren drop", 32'(mem_wren), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("abort no done c%0d", k), 32'(done), 32'd0);
        end
        chk("abort ready", 32'(ready), 32'd1);
        chk("abort writes", 32'(wr_cnt - w0), 32'd0);
        chk("abort mem", mem[8], 32'h11223344);
        chk("abort rdata", rdata, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
